// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Types and constants shared by the program-counter unit
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Fetch sequencer state: one idle cycle after reset, then fetching forever
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  // Byte distance between consecutive instructions
  localparam int unsigned PC_INC = 4;

  // Instruction addresses must be word aligned
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras
//  Brief    : Circular return-address stack; a push onto a full stack
//             overwrites the oldest entry, a push+pop replaces the top entry
//  Revision : 1.0 - initial release
// ============================================================================
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;      // index of the current top entry
  logic [PTR_W:0]   cnt_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] wr_idx;
  logic             pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_MAX);
  assign top_o   = mem_q[ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign ptr_inc = ptr_q + PTR_W'(1);
  // Pop-then-push lands on the slot just vacated, i.e. the current top
  assign wr_idx  = pop_ok ? ptr_q : ptr_inc;

  // Top pointer and occupancy; power-of-two depth makes the pointer wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i && pop_ok) begin
      ptr_q <= ptr_q;
      cnt_q <= cnt_q;
    end else if (push_i) begin
      ptr_q <= ptr_inc;
      if (!full_o) begin
        cnt_q <= cnt_q + (PTR_W+1)'(1);
      end
    end else if (pop_ok) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

  // Entry storage; contents are meaningless while the count is zero
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Brief    : Program counter with exception/return-from-exception, branch
//             redirect, call/return prediction stack and alignment checking
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = 'h80,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             misalign_err,
  output logic             ras_underflow
);

  import cpu_pkg::*;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INC);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mis_q, mis_d;
  logic             unf_q, unf_d;

  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_full;
  logic [WIDTH-1:0] seq_pc;

  assign seq_pc        = pc_q + PC_STEP;
  assign pc_out        = pc_q;
  assign epc           = epc_q;
  assign fetch_valid   = (state_q == RUN);
  assign misalign_err  = mis_q;
  assign ras_underflow = unf_q;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (seq_pc),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );

  // Register the sequencer state, PC, exception PC and the event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      mis_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
      unf_q   <= unf_d;
    end
  end

  // Prioritised next-PC selection and stack control
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    mis_d    = 1'b0;
    unf_d    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (exc_valid) begin
          pc_d  = EXC_VEC;
          epc_d = exc_pc;
        end else if (eret) begin
          if (is_misaligned(epc_q[1:0])) begin
            pc_d  = EXC_VEC;
            mis_d = 1'b1;
          end else begin
            pc_d = epc_q;
          end
        end else if (redirect_valid) begin
          // A faulting branch never reaches its target, so its call is dropped
          if (is_misaligned(redirect_target[1:0])) begin
            pc_d  = EXC_VEC;
            epc_d = redirect_target;
            mis_d = 1'b1;
          end else begin
            pc_d     = redirect_target;
            ras_push = call;
            ras_pop  = call && ret && !ras_empty;
          end
        end else if (ret) begin
          if (ras_empty) begin
            unf_d = 1'b1;
          end else if (!stall) begin
            ras_pop = 1'b1;
            if (is_misaligned(ras_top[1:0])) begin
              pc_d  = EXC_VEC;
              epc_d = ras_top;
              mis_d = 1'b1;
            end else begin
              pc_d = ras_top;
            end
          end
        end else if (fetch_ready && !stall) begin
          pc_d = seq_pc;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Brief    : Self-checking bench for pc_unit: directed scenarios followed by
//             random traffic against a queue-based reference model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] EXC   = 32'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, fetch_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0, exc_pc = '0;
  logic        call = 1'b0, ret = 1'b0, exc_valid = 1'b0, eret = 1'b0;
  logic [31:0] pc_out, epc;
  logic        fetch_valid, ras_empty, misalign_err, ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_run, m_mis, m_unf;
  logic [31:0] m_ras[$];

  pc_unit #(
    .WIDTH     (32),
    .RESET_VEC (32'h0),
    .EXC_VEC   (EXC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call            (call),
    .ret             (ret),
    .exc_valid       (exc_valid),
    .exc_pc          (exc_pc),
    .eret            (eret),
    .pc_out          (pc_out),
    .fetch_valid     (fetch_valid),
    .epc             (epc),
    .ras_empty       (ras_empty),
    .misalign_err    (misalign_err),
    .ras_underflow   (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_run = 1'b0;
    m_mis = 1'b0;
    m_unf = 1'b0;
    m_ras.delete();
  endtask

  // Jump to an address, faulting to the handler when it is not word aligned
  task automatic model_jump(input logic [31:0] t);
    if (t[1:0] != 2'b00) begin
      m_pc  = EXC;
      m_epc = t;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic model_edge();
    logic [31:0] t;
    m_mis = 1'b0;
    m_unf = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
    end else if (exc_valid) begin
      m_pc  = EXC;
      m_epc = exc_pc;
    end else if (eret) begin
      t = m_epc;
      model_jump(t);
    end else if (redirect_valid) begin
      if (redirect_target[1:0] == 2'b00 && call) begin
        if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      model_jump(redirect_target);
    end else if (ret) begin
      if (m_ras.size() == 0) m_unf = 1'b1;
      else if (!stall) begin
        t = m_ras.pop_back();
        model_jump(t);
      end
    end else if (fetch_ready && !stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    chk("pc_out", pc_out, m_pc);
    chk("epc", epc, m_epc);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_run));
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    stall = 0; redirect_valid = 0; call = 0; ret = 0; exc_valid = 0; eret = 0;
    fetch_ready = 1;
  endtask

  task automatic redir(input logic [31:0] t, input logic c);
    idle();
    redirect_valid = 1; redirect_target = t; call = c;
    step();
    idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1; step(); idle();
  endtask

  // Reset asserted away from the clock edge; holds for two edges
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    idle();
    #2;
    apply_reset();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);

    // Boot cycle then sequential fetch 0,4,8
    step();
    chk("boot_fv", 32'(fetch_valid), 32'h1);
    chk("boot_pc", pc_out, 32'h0);
    step(); chk("seq4", pc_out, 32'h4);
    step(); chk("seq8", pc_out, 32'h8);
    step(); step();
    chk("at10", pc_out, 32'h10);

    // Stall holds; redirect overrides stall
    stall = 1;
    repeat (3) step();
    chk("stall_hold", pc_out, 32'h10);
    redirect_valid = 1; redirect_target = 32'h40;
    step();
    chk("redir_stall", pc_out, 32'h40);
    idle();
    fetch_ready = 0; step(); chk("not_ready_hold", pc_out, 32'h40);
    idle();

    // Call and return, then return on an empty stack
    redir(32'h20, 1'b0);
    redir(32'h100, 1'b1);
    chk("call_pc", pc_out, 32'h100);
    do_ret();
    chk("ret_pc", pc_out, 32'h24);
    do_ret();
    chk("unf_hold", pc_out, 32'h24);
    chk("unf_pulse", 32'(ras_underflow), 32'h1);
    step();
    chk("unf_clear", 32'(ras_underflow), 32'h0);

    // Exception beats redirect, then return from exception
    exc_valid = 1; exc_pc = 32'h30; redirect_valid = 1; redirect_target = 32'h200;
    step();
    chk("exc_pc", pc_out, 32'h80);
    chk("exc_epc", epc, 32'h30);
    idle(); eret = 1; stall = 1; step(); idle();
    chk("eret_pc", pc_out, 32'h30);

    // Misaligned redirect
    redir(32'h102, 1'b0);
    chk("mis_pc", pc_out, 32'h80);
    chk("mis_epc", epc, 32'h102);
    chk("mis_pulse", 32'(misalign_err), 32'h1);
    step();
    chk("mis_clear", 32'(misalign_err), 32'h0);

    // Five calls into a four-entry stack, then five returns
    for (int i = 1; i <= 5; i++) redir(32'h1000 * i, 1'b1);
    do_ret(); chk("ras_r5", pc_out, 32'h4004);
    do_ret(); chk("ras_r4", pc_out, 32'h3004);
    do_ret(); chk("ras_r3", pc_out, 32'h2004);
    do_ret(); chk("ras_r2", pc_out, 32'h1004);
    do_ret(); chk("ras_r1_unf", 32'(ras_underflow), 32'h1);
    chk("ras_r1_empty", 32'(ras_empty), 32'h1);

    // Wrap-around of the sequential advance
    redir(32'hFFFF_FFFC, 1'b0);
    step();
    chk("wrap", pc_out, 32'h0);

    // Reset in the middle of a call cycle discards it
    redir(32'h500, 1'b1);
    idle(); redirect_valid = 1; redirect_target = 32'h600; call = 1;
    @(negedge clk);
    apply_reset();
    chk("midrst_empty", 32'(ras_empty), 32'h1);
    idle();
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      exc_valid       = ($urandom_range(99) < 3);
      exc_pc          = $urandom & 32'hFFFF;
      eret            = ($urandom_range(99) < 4);
      redirect_valid  = ($urandom_range(99) < 15);
      redirect_target = ($urandom_range(9) == 0) ? ($urandom & 32'hFFFF)
                                                 : ($urandom & 32'hFFFC);
      call            = ($urandom_range(1) == 1);
      ret             = ($urandom_range(99) < 15);
      stall           = ($urandom_range(99) < 20);
      fetch_ready     = ($urandom_range(99) < 80);
      if ($urandom_range(999) == 0) begin
        @(negedge clk);
        apply_reset();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
